contador_param: RTL

Parametrised up/down counter for the counter/datapath library and the generalised replacement for the fixed 8-bit up/down counter. It adds:
- configurable width, reset value and count bounds;
- wrap or saturate at the bounds;
- programmable step, synchronous load and clock enable;
- level or rising-edge sensing of the count inputs;
- bound flags and overflow/underflow pulses for chaining or driving displays.

---
 rtl/contador_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/contador_param.sv
// contador_param: parametrised up/down counter with configurable bounds,
// wrap or saturate at the bounds, programmable step, synchronous load,
// clock enable and level or rising-edge sensing of the count inputs.
// Bound flags are decoded from the count. Overflow and underflow are
// registered one-cycle pulses, suitable for chaining counters or driving
// display logic.
module contador_param #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 106,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 2**WIDTH - 1,
  parameter bit SATURATE    = 1'b0,
  parameter bit EDGE_MODE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             acrescer,
  input  logic             decrecer,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] saida,
  output logic             at_max,
  output logic             at_min,
  output logic             overflow,
  output logic             underflow
);

  // Reject parameter sets that would let the count escape its bounds.
  if (WIDTH < 2 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      MAX_VAL > 2**WIDTH - 1 ||
      RESET_VALUE < MIN_VAL || RESET_VALUE > MAX_VAL) begin : g_bad_params
    $error("contador_param: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);
  // Bounds widened by one bit so they compare against the unwrapped sum
  // and the signed difference without truncation.
  localparam logic        [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic signed [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);

  logic             acrescer_q;
  logic             decrecer_q;
  logic             up;
  logic             dn;
  logic [WIDTH:0]   sum;
  logic signed [WIDTH:0] diff;
  logic [WIDTH-1:0] saida_next;
  logic             overflow_next;
  logic             underflow_next;

  // Count events: raw level, or a rising edge against the previous sample.
  assign up = EDGE_MODE ? (acrescer & ~acrescer_q) : acrescer;
  assign dn = EDGE_MODE ? (decrecer & ~decrecer_q) : decrecer;

  // One extra bit keeps the carry of the up-count and the sign of the
  // down-count, so crossings are detected without modular aliasing.
  assign sum  = {1'b0, saida} + {1'b0, step};
  assign diff = $signed({1'b0, saida}) - $signed({1'b0, step});

  // Next-state selection in priority order: load, enable, request, step.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    saida_next     = saida;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (load) begin
      if (load_val < MIN_W)      saida_next = MIN_W;
      else if (load_val > MAX_W) saida_next = MAX_W;
      else                       saida_next = load_val;
    end else if (en && (up ^ dn) && (step != '0)) begin
      if (up) begin
        if (sum > MAX_X) begin
          saida_next    = SATURATE ? MAX_W : MIN_W;
          overflow_next = 1'b1;
        end else begin
          saida_next = sum[WIDTH-1:0];
        end
      end else begin
        if (diff < MIN_X) begin
          saida_next     = SATURATE ? MIN_W : MAX_W;
          underflow_next = 1'b1;
        end else begin
          saida_next = diff[WIDTH-1:0];
        end
      end
    end
  end

  // Count register, crossing pulses and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida      <= RESET_W;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      acrescer_q <= 1'b0;
      decrecer_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      saida      <= saida_next;
      overflow   <= overflow_next;
      underflow  <= underflow_next;
      // History follows the raw inputs every cycle, so edges seen during
      // load or with en low are consumed rather than deferred.
      acrescer_q <= acrescer;
      decrecer_q <= decrecer;
    end
  end

  assign at_max = (saida == MAX_W);
  assign at_min = (saida == MIN_W);

endmodule
